dbus_arbiter: RTL
=================

// Module: dbus_arbiter
// PURPOSE
//   Shares one data bus (dbus_req_t/dbus_resp_t) between NREQ requesters, e.g. the load/store
//   unit (port 0) and the Sv39 page-table walker driven by satp (port 1). Grants one whole
//   transaction at a time (valid .. data_ok), latches the winner's request, routes the response
//   back to the winner only. Sits between the memory-stage units and the core's single dbus.
// PARAMETERS
//   NREQ      2   number of requesters (2..8)
//   IDX_W     $clog2(NREQ)  grant index width (derived; not overridden)
// PORTS
//   clk        in   1              clock; all logic on posedge
//   reset      in   1              synchronous, active-high reset
//   ireq       in   dbus_req_t[NREQ]   per-requester request
//   iresp      out  dbus_resp_t[NREQ]  per-requester response
//   oreq       out  dbus_req_t         request to shared dbus
//   oresp      in   dbus_resp_t        response from shared dbus
//   busy       out  1              a transaction is outstanding on oreq
//   grant_idx  out  IDX_W          index of current owner (valid when busy)
// BEHAVIOUR
//   - One clock, synchronous active-high reset. Reset: state=IDLE, oreq='0 (valid=0, size=MSIZE1),
//     iresp[*]='0, busy=0, grant_idx=0, rr_ptr=0. Reset mid-transaction aborts unconditionally.
//   - FSM IDLE -> BUSY -> IDLE.
//     IDLE: if any ireq[i].valid, pick winner (round-robin from rr_ptr), latch ireq[win] into
//       req_q, grant_idx<=win, busy<=1, go BUSY. No valid -> stay IDLE.
//     BUSY: oreq=req_q (registered, stable for whole transaction; requester changes ignored).
//       iresp[grant_idx].addr_ok/data_ok/data = oresp fields; all other iresp = '0.
//       On oresp.data_ok: go IDLE, busy<=0, req_q.valid<=0, rr_ptr<=grant_idx+1 (mod NREQ).
//   - Latency: valid seen in cycle T -> oreq.valid in T+1; data_ok in T+k forwarded to grantee
//     combinationally in T+k; earliest next grant decided in T+k+1 (one bubble, by design).
//   - Round-robin: search order rr_ptr, rr_ptr+1, ... wrapping at NREQ-1 -> 0; no starvation:
//     each requester waits at most NREQ-1 transactions.
//   - Simultaneous valids in IDLE: only the winner is latched; losers see iresp='0 and must hold.
//   - addr_ok without data_ok: forwarded, FSM stays BUSY. data_ok in IDLE: ignored, iresp='0.
//   - Requester dropping valid while owner: transaction still completes (req_q); its data_ok pulse
//     still delivered. Requesters hold valid until their own data_ok (LSU contract).
//   - oreq.addr/size/strobe/data are '0 whenever state=IDLE.
// CONFIGURATION
//   DBUS_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins (PTW can be placed at
//     port 0 to preempt LSU between transactions); rr_ptr held at 0 and unused.
//   Undefined (default): round-robin as above. Grant-holding, latching and routing identical.
// STRUCTURE
//   - Shared package (common): dbus_req_t, dbus_resp_t, msize_t already present; add
//     DBUS_ARB_MAX_REQ=8 constant. Local typedef arb_state_t {IDLE, BUSY}.
//   - Sub-module rr_picker #(N): inputs req[N], ptr; outputs any, idx. Pure combinational
//     rotate-priority-encoder; fixed-priority variant selected by the macro inside it.
// TESTING
//   1. Reset with ireq[0].valid=1 held: oreq.valid=0, busy=0 during reset; first cycle after
//      release latches port 0, oreq.valid=1 next cycle, grant_idx=0.
//   2. Both valid at T, rr_ptr=0: port 0 granted (addr 0x8000_0000 load MSIZE8); data_ok with
//      data=0x1122_3344_5566_7788 reaches iresp[0] only; iresp[1].data_ok=0; then port 1 granted
//      at T+k+1 with its own addr 0x8000_1000.
//   3. Continuous valids on both ports for 8 transactions: grants alternate 0,1,0,1...; with
//      DBUS_ARB_FIXED_PRIO_EN defined: all 8 go to port 0.
//   4. Store strobe=0xF0 data=0xDEAD_BEEF_0000_0000 from port 1; requester changes addr
//      mid-transaction: oreq fields stay latched until data_ok, then busy=0.
//   5. addr_ok pulse, then data_ok 5 cycles later: FSM BUSY for 5 cycles; spurious data_ok in IDLE
//      produces no iresp activity.
//   6. reset asserted mid-BUSY: next cycle state IDLE, oreq.valid=0, rr_ptr=0.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus types and arbiter constants.
//   msize_t     : access size encoding (MSIZE1 is the all-zero value)
//   dbus_req_t  : valid/addr/size/strobe/data request toward memory
//   dbus_resp_t : addr_ok/data_ok/data response from memory
package dbus_arbiter_pkg;

  localparam int DBUS_ARB_MAX_REQ = 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundle of the arbiter's bus-side signals.
//   ireq/iresp : per-requester request in / response out
//   oreq/oresp : shared dbus request out / response in
//   busy       : transaction outstanding on oreq
//   grant_idx  : current owner (meaningful while busy)
// Modports: slave = the arbiter, master = requesters plus memory side.
interface dbus_arbiter_if #(
  parameter int NREQ = 2
);
  import dbus_arbiter_pkg::*;

  localparam int IDX_W = $clog2(NREQ);

  dbus_req_t  [NREQ-1:0] ireq;
  dbus_resp_t [NREQ-1:0] iresp;
  dbus_req_t             oreq;
  dbus_resp_t            oresp;
  logic                  busy;
  logic [IDX_W-1:0]      grant_idx;

  modport slave (
    input  ireq, oresp,
    output iresp, oreq, busy, grant_idx
  );

  modport master (
    output ireq, oresp,
    input  iresp, oreq, busy, grant_idx
  );
endinterface

// File: rtl/dbus_arbiter_rr_picker.sv
// Combinational winner picker.
//   req : request vector, ptr : first index to search from
//   any : some request present, idx : winning index
// Default: rotating priority starting at ptr, wrapping N-1 -> 0.
// With DBUS_ARB_FIXED_PRIO_EN defined: lowest index wins and ptr is ignored.
module dbus_arbiter_rr_picker #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

`ifdef DBUS_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    any = |req;
    idx = '0;
    // Descending scan so the lowest set index is the last write.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end
`else
  always_comb begin
    int              j;
    logic [IW-1:0]   jj;
    any = |req;
    idx = '0;
    j   = 0;
    jj  = '0;
    // Scan offsets from farthest to nearest so the first index at/after ptr wins.
    for (int off = N - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (req[jj]) idx = jj;
    end
  end
`endif

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one data bus between NREQ requesters, one whole transaction
// (valid .. data_ok) at a time. The winner's request is latched and replayed
// on oreq until data_ok; the response is routed to the winner only.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dbus_arbiter_if.slave (ireq/iresp/oreq/oresp/busy/grant_idx)
// Config macro: DBUS_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic          clk,
  input  logic          reset,
  dbus_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic {IDLE, BUSY} arb_state_t;

  arb_state_t       state_q, state_d;
  dbus_req_t        req_q, req_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] rr_q, rr_d;

  logic [NREQ-1:0]  valid_vec;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  dbus_resp_t [NREQ-1:0] iresp_c;

  always_comb begin
    for (int i = 0; i < NREQ; i++) valid_vec[i] = bus.ireq[i].valid;
  end

  dbus_arbiter_rr_picker #(.N(NREQ)) u_pick (
    .req (valid_vec),
    .ptr (rr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      gidx_q  <= '0;
      busy_q  <= 1'b0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gidx_q  <= gidx_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    gidx_d  = gidx_q;
    busy_d  = busy_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_d   = bus.ireq[pick_idx];
          gidx_d  = pick_idx;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.oresp.data_ok) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          // Clear the whole latch so oreq is all-zero while idle.
          req_d   = '0;
`ifdef DBUS_ARB_FIXED_PRIO_EN
          rr_d    = '0;
`else
          rr_d    = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + IDX_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response goes to the owner only; idle-time responses are dropped.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      iresp_c[i] = '0;
      if (state_q == BUSY && gidx_q == IDX_W'(i)) iresp_c[i] = bus.oresp;
    end
  end

  assign bus.iresp     = iresp_c;
  assign bus.oreq      = (state_q == BUSY) ? req_q : '0;
  assign bus.busy      = busy_q;
  assign bus.grant_idx = gidx_q;

endmodule
